// File: rtl/enoc_switch_allocator.sv
// Switch allocator for the ENoC wormhole router: per-output round-robin
// arbitration with a packet lock that holds an output until the tail flit passes.
module enoc_switch_allocator #(
   parameter int PORTS = 5
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     ce,
   input  logic [PORTS*PORTS-1:0]   i_output_req,
   input  logic [PORTS-1:0]         i_tail,
   input  logic [PORTS-1:0]         i_output_ready,
   output logic [PORTS-1:0]         o_input_grant,
   output logic [PORTS*PORTS-1:0]   o_xbar_sel,
   output logic [PORTS-1:0]         o_output_valid
);
   localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

   state_e        state_q [PORTS];
   state_e        state_d [PORTS];
   logic [IW-1:0] owner_q [PORTS];
   logic [IW-1:0] owner_d [PORTS];
   logic [IW-1:0] ptr_q   [PORTS];
   logic [IW-1:0] ptr_d   [PORTS];
   logic          run_q;
   logic          run_d;

   logic [PORTS-1:0] req [PORTS];
   logic [IW-1:0]    win [PORTS];
   logic             hit [PORTS];
   logic             en;
   int               idx;

   // Keep only the lowest set bit of each input slice so a malformed
   // multi-hot request can never claim two outputs at once.
   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         req[i] = i_output_req[i*PORTS +: PORTS] &
                  (~i_output_req[i*PORTS +: PORTS] + PORTS'(1));
      end
   end

   always_comb begin
      run_d          = 1'b1;
      en             = ce & run_q;
      idx            = 0;
      o_xbar_sel     = '0;
      o_output_valid = '0;
      o_input_grant  = '0;
      for (int j = 0; j < PORTS; j++) begin
         state_d[j] = state_q[j];
         owner_d[j] = owner_q[j];
         ptr_d[j]   = ptr_q[j];
         hit[j]     = 1'b0;
         win[j]     = '0;
         if (state_q[j] == LOCKED) begin
            hit[j] = req[owner_q[j]][j];
            win[j] = owner_q[j];
         end else begin
            // Scan farthest-first so the candidate nearest ptr_j is written last.
            for (int k = PORTS-1; k >= 0; k--) begin
               idx = int'(ptr_q[j]) + k;
               if (idx >= PORTS) idx = idx - PORTS;
               if (req[idx][j]) begin
                  hit[j] = 1'b1;
                  win[j] = IW'(idx);
               end
            end
         end
         if (en && hit[j] && i_output_ready[j]) begin
            o_xbar_sel[j*PORTS + int'(win[j])] = 1'b1;
            o_output_valid[j]                  = 1'b1;
            if (state_q[j] == LOCKED) begin
               if (i_tail[win[j]]) state_d[j] = IDLE;
            end else begin
               ptr_d[j] = (int'(win[j]) == PORTS-1) ? '0 : win[j] + IW'(1);
               if (!i_tail[win[j]]) begin
                  state_d[j] = LOCKED;
                  owner_d[j] = win[j];
               end
            end
         end
      end
      for (int j = 0; j < PORTS; j++) begin
         for (int i = 0; i < PORTS; i++) begin
            o_input_grant[i] = o_input_grant[i] | o_xbar_sel[j*PORTS + i];
         end
      end
   end

   // run_q holds off grants until the first edge after reset is released.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q <= 1'b0;
         for (int j = 0; j < PORTS; j++) begin
            state_q[j] <= IDLE;
            owner_q[j] <= '0;
            ptr_q[j]   <= '0;
         end
      end else begin
         run_q <= run_d;
         for (int j = 0; j < PORTS; j++) begin
            state_q[j] <= state_d[j];
            owner_q[j] <= owner_d[j];
            ptr_q[j]   <= ptr_d[j];
         end
      end
   end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Bench for enoc_switch_allocator: directed packet scenarios checked against a
// per-output lock/pointer model every cycle, plus hand-computed grant patterns.
module tb_enoc_switch_allocator;
   localparam int P = 5;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic          ce      = 1'b0;
   logic [24:0]   req     = '0;
   logic [4:0]    tail    = '0;
   logic [4:0]    ready   = '0;
   logic [4:0]    grant;
   logic [24:0]   sel;
   logic [4:0]    valid;

   int            nvec = 0;
   int            nerr = 0;
   logic          lit_en = 1'b0;
   logic [4:0]    lit_g  = '0;
   logic [4:0]    lit_v  = '0;

   enoc_switch_allocator #(.PORTS(P)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ce             (ce),
      .i_output_req   (req),
      .i_tail         (tail),
      .i_output_ready (ready),
      .o_input_grant  (grant),
      .o_xbar_sel     (sel),
      .o_output_valid (valid)
   );

   always #5 clk = ~clk;

   function automatic logic [24:0] rq(input int i, input int j);
      logic [24:0] v;
      v = '0;
      v[i*P + j] = 1'b1;
      return v;
   endfunction

   task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
      nvec = nvec + 1;
      if (act !== exp) begin
         nerr = nerr + 1;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: each output is either free (round-robin from its pointer) or
   // owned by one input until that input's tail flit is sent.
   initial begin
      int   m_locked [P];
      int   m_owner  [P];
      int   m_ptr    [P];
      int   n_locked [P];
      int   n_owner  [P];
      int   n_ptr    [P];
      int   dest     [P];
      int   w;
      int   cand;
      bit   awake;
      bit   pending;
      bit   en;
      logic last_clk;
      logic [24:0] esel;
      logic [4:0]  eg;
      logic [4:0]  ev;
      awake    = 1'b0;
      pending  = 1'b0;
      last_clk = 1'b0;
      for (int j = 0; j < P; j++) begin
         m_locked[j] = 0; m_owner[j] = 0; m_ptr[j] = 0;
         n_locked[j] = 0; n_owner[j] = 0; n_ptr[j] = 0;
      end
      forever begin
         @(posedge clk or negedge clk or negedge reset_n);
         if (!reset_n) begin
            for (int j = 0; j < P; j++) begin
               m_locked[j] = 0; m_owner[j] = 0; m_ptr[j] = 0;
            end
            awake   = 1'b0;
            pending = 1'b0;
         end
         if (clk !== last_clk) begin
            last_clk = clk;
            if (clk) begin
               if (reset_n) begin
                  if (pending) begin
                     for (int j = 0; j < P; j++) begin
                        m_locked[j] = n_locked[j];
                        m_owner[j]  = n_owner[j];
                        m_ptr[j]    = n_ptr[j];
                     end
                  end
                  awake = 1'b1;
               end
               pending = 1'b0;
            end else begin
               en = (ce === 1'b1) && awake && (reset_n === 1'b1);
               for (int i = 0; i < P; i++) begin
                  assert ($onehot0(req[i*P +: P]))
                     else $error("illegal multi-hot request on input %0d", i);
                  dest[i] = -1;
                  for (int j = P-1; j >= 0; j--) begin
                     if (req[i*P + j]) dest[i] = j;
                  end
               end
               esel = '0; eg = '0; ev = '0;
               for (int j = 0; j < P; j++) begin
                  n_locked[j] = m_locked[j];
                  n_owner[j]  = m_owner[j];
                  n_ptr[j]    = m_ptr[j];
                  w = -1;
                  if (en && ready[j]) begin
                     if (m_locked[j] != 0) begin
                        if (dest[m_owner[j]] == j) w = m_owner[j];
                     end else begin
                        for (int k = 0; k < P; k++) begin
                           cand = (m_ptr[j] + k) % P;
                           if (w < 0 && dest[cand] == j) w = cand;
                        end
                     end
                  end
                  if (w >= 0) begin
                     esel[j*P + w] = 1'b1;
                     ev[j] = 1'b1;
                     eg[w] = 1'b1;
                     if (m_locked[j] != 0) begin
                        if (tail[w]) n_locked[j] = 0;
                     end else begin
                        n_ptr[j] = (w + 1) % P;
                        if (!tail[w]) begin
                           n_locked[j] = 1;
                           n_owner[j]  = w;
                        end
                     end
                  end
               end
               check("grant", 25'(grant), 25'(eg));
               check("xbar_sel", sel, esel);
               check("valid", 25'(valid), 25'(ev));
               if (lit_en) begin
                  check("lit_grant", 25'(grant), 25'(lit_g));
                  check("lit_valid", 25'(valid), 25'(lit_v));
               end
               pending = 1'b1;
            end
         end
      end
   end

   task automatic cyc(input logic [24:0] r, input logic [4:0] t, input logic [4:0] rd,
                      input logic c, input logic [4:0] g, input logic [4:0] v);
      req = r; tail = t; ready = rd; ce = c;
      lit_en = 1'b1; lit_g = g; lit_v = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [24:0] par;
      logic [4:0]  ord [3];
      ord[0] = 5'b00010; ord[1] = 5'b01000; ord[2] = 5'b10000;

      // Reset held with live requests, then released idle
      for (int i = 0; i < 3; i++)
         cyc(rq(1,2) | rq(0,0) | rq(4,4), 5'h1F, 5'h1F, 1'b1, 5'b0, 5'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++)
         cyc('0, 5'h00, 5'h1F, 1'b1, 5'b0, 5'b0);

      // Round-robin among n, s, w on output e
      for (int i = 0; i < 6; i++)
         cyc(rq(1,2) | rq(3,2) | rq(4,2), 5'h1F, 5'h1F, 1'b1, ord[i % 3], 5'b00100);

      // Wormhole lock: w sends 4 flits to c while n waits
      cyc(rq(4,0),           5'b00000, 5'h1F, 1'b1, 5'b10000, 5'b00001);
      cyc(rq(4,0) | rq(1,0), 5'b00000, 5'h1F, 1'b1, 5'b10000, 5'b00001);
      cyc(rq(4,0) | rq(1,0), 5'b00000, 5'h1F, 1'b1, 5'b10000, 5'b00001);
      cyc(rq(4,0) | rq(1,0), 5'b10000, 5'h1F, 1'b1, 5'b10000, 5'b00001);
      cyc(rq(1,0),           5'b00010, 5'h1F, 1'b1, 5'b00010, 5'b00001);

      // Back-pressure and an owner bubble inside a lock on e
      cyc(rq(4,2),           5'b00000, 5'h1F,    1'b1, 5'b10000, 5'b00100);
      cyc(rq(4,2) | rq(3,2), 5'b00000, 5'b11011, 1'b1, 5'b00000, 5'b00000);
      cyc(rq(4,2) | rq(3,2), 5'b00000, 5'b11011, 1'b1, 5'b00000, 5'b00000);
      cyc(rq(3,2),           5'b00000, 5'h1F,    1'b1, 5'b00000, 5'b00000);
      cyc(rq(4,2) | rq(3,2), 5'b10000, 5'h1F,    1'b1, 5'b10000, 5'b00100);
      cyc(rq(3,2),           5'b01000, 5'h1F,    1'b1, 5'b01000, 5'b00100);

      // All five outputs at once, clock-enable, loopback
      par = rq(0,1) | rq(1,3) | rq(2,4) | rq(3,2) | rq(4,0);
      cyc(par, 5'h1F, 5'h1F, 1'b1, 5'h1F, 5'h1F);
      cyc(par, 5'h1F, 5'h1F, 1'b0, 5'h00, 5'h00);
      cyc(par, 5'h1F, 5'h1F, 1'b1, 5'h1F, 5'h1F);
      cyc(rq(0,0),           5'b00000, 5'h1F, 1'b1, 5'b00001, 5'b00001);
      cyc(rq(0,0) | rq(1,0), 5'b00000, 5'h1F, 1'b0, 5'b00000, 5'b00000);
      cyc(rq(0,0) | rq(1,0), 5'b00001, 5'h1F, 1'b1, 5'b00001, 5'b00001);
      cyc(rq(1,0),           5'b00010, 5'h1F, 1'b1, 5'b00010, 5'b00001);

      // Reset pulse while e holds output s mid-packet
      cyc(rq(2,3),           5'b00000, 5'h1F, 1'b1, 5'b00100, 5'b01000);
      cyc(rq(2,3) | rq(1,3), 5'b00000, 5'h1F, 1'b1, 5'b00100, 5'b01000);
      req = rq(1,3) | rq(2,3) | rq(4,3); tail = 5'b00000; ready = 5'h1F; ce = 1'b1;
      lit_en = 1'b1; lit_g = 5'b00000; lit_v = 5'b00000;
      #1 reset_n = 1'b0;
      #5 reset_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(rq(1,3) | rq(2,3) | rq(4,3), 5'b00010, 5'h1F, 1'b1, 5'b00010, 5'b01000);
      cyc('0, 5'b00000, 5'h1F, 1'b1, 5'b00000, 5'b00000);

      lit_en = 1'b0;
      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
